// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types, error codes and CRC step functions for the byte-stream ALU
package alu_pkg;

  // Opcodes carried in the control byte; the unused encodings are named so they can be reported
  typedef enum logic [2:0] {
    and_op     = 3'b000,
    or_op      = 3'b001,
    data_error = 3'b010,
    op_error   = 3'b011,
    add_op     = 3'b100,
    sub_op     = 3'b101,
    crc_error  = 3'b110,
    no_op      = 3'b111
  } operation_t;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_EXEC    = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  localparam logic [7:0] CRC_ERROR  = 8'hA5;
  localparam logic [7:0] DATA_ERROR = 8'hC9;
  localparam logic [7:0] OP_ERROR   = 8'h93;

  // One bit of a serial CRC4, x^4+x+1, MSB-first
  function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic b);
    logic fb;
    fb = crc[3] ^ b;
    return {crc[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
  endfunction

  // One bit of a serial CRC3, x^3+x+1, MSB-first
  function automatic logic [2:0] crc3_step(input logic [2:0] crc, input logic b);
    logic fb;
    fb = crc[2] ^ b;
    return {crc[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
  endfunction

endpackage

// File: rtl/alu_stream_exec.sv
// rtl/alu_stream_exec.sv - combinational ALU operation, flags and result CRC3
module alu_stream_exec
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [2:0]        i_op,
  output logic [DATA_W-1:0] o_result,
  output logic [3:0]        o_flags,
  output logic [2:0]        o_crc,
  output logic              o_op_ok
);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_result;
  logic              w_carry;
  logic              w_ovf;
  logic [3:0]        w_flags;
  logic [2:0]        w_crc;

  // Compute the selected operation; the extra top bit of sum/diff is carry/borrow
  always_comb begin
    w_sum    = {1'b0, i_a} + {1'b0, i_b};
    w_diff   = {1'b0, i_a} - {1'b0, i_b};
    w_result = '0;
    w_carry  = 1'b0;
    w_ovf    = 1'b0;
    o_op_ok  = 1'b1;
    case (i_op)
      and_op: w_result = i_a & i_b;
      or_op:  w_result = i_a | i_b;
      add_op: begin
        w_result = w_sum[DATA_W-1:0];
        w_carry  = w_sum[DATA_W];
        w_ovf    = (i_a[DATA_W-1] == i_b[DATA_W-1]) && (w_result[DATA_W-1] != i_a[DATA_W-1]);
      end
      sub_op: begin
        w_result = w_diff[DATA_W-1:0];
        w_carry  = w_diff[DATA_W];
        w_ovf    = (i_a[DATA_W-1] != i_b[DATA_W-1]) && (w_result[DATA_W-1] != i_a[DATA_W-1]);
      end
      default: o_op_ok = 1'b0;
    endcase
    w_flags = {w_carry, w_ovf, (w_result == '0), w_result[DATA_W-1]};
  end

  // Serial CRC3 over result then flags, unrolled into one combinational chain
  always_comb begin
    w_crc = 3'b000;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      w_crc = crc3_step(w_crc, w_result[i]);
    end
    for (int i = 3; i >= 0; i--) begin
      w_crc = crc3_step(w_crc, w_flags[i]);
    end
  end

  assign o_result = w_result;
  assign o_flags  = w_flags;
  assign o_crc    = w_crc;

endmodule

// File: rtl/alu_stream_core.sv
// rtl/alu_stream_core.sv - byte-stream ALU: frame collection, CRC4/framing checks, result beat
module alu_stream_core
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_ctl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_err,
  output logic [DATA_W-1:0] out_result,
  output logic [3:0]        out_flags,
  output logic [2:0]        out_crc,
  output logic [7:0]        out_err_code
);

  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = $clog2(2 * NB + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(2 * NB);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(2 * NB + 1);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*DATA_W-1:0] r_shift;
  logic [3:0]          r_crc4;
  logic [2:0]          r_op;
  logic [3:0]          r_crc_rx;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_out_err;
  logic [DATA_W-1:0]   r_out_result;
  logic [3:0]          r_out_flags;
  logic [2:0]          r_out_crc;
  logic [7:0]          r_out_err_code;

  logic                w_accept;
  logic [3:0]          w_crc4_next;
  logic [3:0]          w_crc4_final;
  logic [DATA_W-1:0]   w_result;
  logic [3:0]          w_flags;
  logic [2:0]          w_crc3;
  logic                w_op_ok;

  assign w_accept = in_valid & r_in_ready;

  // CRC4 advanced by a whole data byte, and the frame CRC once the opcode bits are folded in
  always_comb begin
    w_crc4_next = r_crc4;
    for (int i = 7; i >= 0; i--) begin
      w_crc4_next = crc4_step(w_crc4_next, in_data[i]);
    end
    w_crc4_final = r_crc4;
    for (int i = 2; i >= 0; i--) begin
      w_crc4_final = crc4_step(w_crc4_final, r_op[i]);
    end
  end

  alu_stream_exec #(
    .DATA_W (DATA_W)
  ) u_exec (
    .i_a      (r_shift[2*DATA_W-1:DATA_W]),
    .i_b      (r_shift[DATA_W-1:0]),
    .i_op     (r_op),
    .o_result (w_result),
    .o_flags  (w_flags),
    .o_crc    (w_crc3),
    .o_op_ok  (w_op_ok)
  );

  // Frame FSM: collect bytes, evaluate for one cycle, then hold the beat until taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_COLLECT;
      r_cnt          <= '0;
      r_shift        <= '0;
      r_crc4         <= 4'h0;
      r_op           <= 3'b000;
      r_crc_rx       <= 4'h0;
      r_in_ready     <= 1'b1;
      r_out_valid    <= 1'b0;
      r_out_err      <= 1'b0;
      r_out_result   <= '0;
      r_out_flags    <= 4'h0;
      r_out_crc      <= 3'b000;
      r_out_err_code <= 8'h00;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (w_accept) begin
            if (in_ctl) begin
              r_op       <= in_data[6:4];
              r_crc_rx   <= in_data[3:0];
              r_in_ready <= 1'b0;
              r_state    <= ST_EXEC;
            end else begin
              r_shift <= {r_shift[2*DATA_W-9:0], in_data};
              r_crc4  <= w_crc4_next;
              if (r_cnt != CNT_SAT) begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
        end
        ST_EXEC: begin
          r_out_valid <= 1'b1;
          r_state     <= ST_HOLD;
          if (r_cnt != CNT_FULL || r_crc_rx != w_crc4_final || !w_op_ok) begin
            r_out_err      <= 1'b1;
            r_out_result   <= '0;
            r_out_flags    <= 4'h0;
            r_out_crc      <= 3'b000;
            if (r_cnt != CNT_FULL) begin
              r_out_err_code <= DATA_ERROR;
            end else if (r_crc_rx != w_crc4_final) begin
              r_out_err_code <= CRC_ERROR;
            end else begin
              r_out_err_code <= OP_ERROR;
            end
          end else begin
            r_out_err      <= 1'b0;
            r_out_result   <= w_result;
            r_out_flags    <= w_flags;
            r_out_crc      <= w_crc3;
            r_out_err_code <= 8'h00;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_cnt       <= '0;
            r_crc4      <= 4'h0;
            r_state     <= ST_COLLECT;
          end
        end
        default: begin
          r_state    <= ST_COLLECT;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_err      = r_out_err;
  assign out_result   = r_out_result;
  assign out_flags    = r_out_flags;
  assign out_crc      = r_out_crc;
  assign out_err_code = r_out_err_code;

endmodule

// File: tb/tb_alu_stream_core.sv
// tb/tb_alu_stream_core.sv - randomized self-checking bench for alu_stream_core
module tb_alu_stream_core;

  localparam int DW = 32;
  localparam int NB = DW / 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          in_ctl;
  logic          out_valid;
  logic          out_ready;
  logic          out_err;
  logic [DW-1:0] out_result;
  logic [3:0]    out_flags;
  logic [2:0]    out_crc;
  logic [7:0]    out_err_code;

  int n_checks;
  int n_fail;

  logic          exp_err;
  logic [7:0]    exp_code;
  logic [DW-1:0] exp_res;
  logic [3:0]    exp_flags;
  logic [2:0]    exp_crc;

  alu_stream_core #(.DATA_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_ctl       (in_ctl),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_err      (out_err),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .out_crc      (out_crc),
    .out_err_code (out_err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CRC as the remainder of polynomial long division of msg * x^deg by the generator
  function automatic logic [3:0] poly_rem(input bit msg[$], input int deg, input logic [4:0] poly);
    bit m[$];
    logic [3:0] r;
    m = msg;
    for (int i = 0; i < deg; i++) m.push_back(1'b0);
    for (int i = 0; i + deg < m.size(); i++) begin
      if (m[i]) begin
        for (int j = 0; j <= deg; j++) m[i+j] = m[i+j] ^ poly[deg-j];
      end
    end
    r = 4'h0;
    for (int k = 0; k < deg; k++) r = {r[2:0], m[m.size()-deg+k]};
    return r;
  endfunction

  function automatic logic [3:0] model_crc4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [2:0] op);
    bit q[$];
    for (int i = DW - 1; i >= 0; i--) q.push_back(a[i]);
    for (int i = DW - 1; i >= 0; i--) q.push_back(b[i]);
    for (int i = 2; i >= 0; i--) q.push_back(op[i]);
    return poly_rem(q, 4, 5'b10011);
  endfunction

  function automatic logic [2:0] model_crc3(input logic [DW-1:0] r, input logic [3:0] f);
    bit q[$];
    logic [3:0] rem;
    for (int i = DW - 1; i >= 0; i--) q.push_back(r[i]);
    for (int i = 3; i >= 0; i--) q.push_back(f[i]);
    rem = poly_rem(q, 3, 5'b01011);
    return rem[2:0];
  endfunction

  // Expected beat for a frame of ndata data bytes followed by the given control byte
  task automatic model(input int ndata, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [2:0] op, input logic [3:0] crc_sent);
    logic [DW-1:0] r;
    logic c, v;
    exp_err = 1'b1; exp_res = '0; exp_flags = 4'h0; exp_crc = 3'b000;
    if (ndata != 2 * NB) begin
      exp_code = 8'hC9;
    end else if (crc_sent != model_crc4(a, b, op)) begin
      exp_code = 8'hA5;
    end else if (!(op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b101)) begin
      exp_code = 8'h93;
    end else begin
      c = 1'b0; v = 1'b0;
      case (op)
        3'b000: r = a & b;
        3'b001: r = a | b;
        3'b100: begin
          r = a + b;
          c = (r < a);
          v = ($signed(a) >= 0 && $signed(b) >= 0 && $signed(r) < 0) ||
              ($signed(a) < 0 && $signed(b) < 0 && $signed(r) >= 0);
        end
        default: begin
          r = a - b;
          c = (a < b);
          v = ($signed(a) >= 0 && $signed(b) < 0 && $signed(r) < 0) ||
              ($signed(a) < 0 && $signed(b) >= 0 && $signed(r) >= 0);
        end
      endcase
      exp_err = 1'b0; exp_code = 8'h00; exp_res = r;
      exp_flags = {c, v, (r == '0), r[DW-1]};
      exp_crc = model_crc3(r, exp_flags);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic ctl);
    int n;
    in_valid = 1'b1; in_data = d; in_ctl = ctl;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_byte_timeout in_ready=%0b required=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_ctl = 1'b0;
  endtask

  task automatic send_frame(input int ndata, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [2:0] op, input logic [3:0] crc);
    logic [2*DW-1:0] ab;
    ab = {a, b};
    for (int i = 0; i < ndata; i++) begin
      if (i < 2 * NB) send_byte(ab[2*DW-1-8*i -: 8], 1'b0);
      else send_byte(8'($urandom), 1'b0);
    end
    send_byte({1'b0, op, crc}, 1'b1);
    model(ndata, a, b, op, crc);
  endtask

  task automatic expect_beat(input string name, input int delay);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s out_valid timeout got=%0b required=1", name, out_valid);
    end
    n_checks++;
    if (out_err !== exp_err) begin
      n_fail++; $display("FAIL %s out_err got=%0b required=%0b", name, out_err, exp_err);
    end
    n_checks++;
    if (out_err_code !== exp_code) begin
      n_fail++; $display("FAIL %s err_code got=%h required=%h", name, out_err_code, exp_code);
    end
    n_checks++;
    if (out_result !== exp_res) begin
      n_fail++; $display("FAIL %s result got=%h required=%h", name, out_result, exp_res);
    end
    n_checks++;
    if (out_flags !== exp_flags) begin
      n_fail++; $display("FAIL %s flags got=%b required=%b", name, out_flags, exp_flags);
    end
    n_checks++;
    if (out_crc !== exp_crc) begin
      n_fail++; $display("FAIL %s crc3 got=%b required=%b", name, out_crc, exp_crc);
    end
    repeat (delay) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_ctl = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_err, out_result, out_flags, out_crc, out_err_code} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h required=0",
               {out_valid, out_err, out_result, out_flags, out_crc, out_err_code});
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready got=%0b required=1", in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_basic;
    send_frame(2 * NB, 1, 2, 3'b100, model_crc4(1, 2, 3'b100));
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL latency_early out_valid got=%0b required=0", out_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL latency_ontime out_valid got=%0b required=1", out_valid);
    end
    n_checks++;
    if (out_result !== DW'(3) || out_flags !== 4'b0000) begin
      n_fail++; $display("FAIL add_1_2 got=%h/%b required=3/0000", out_result, out_flags);
    end
    expect_beat("add_1_2", 0);
  endtask

  task automatic test_overflow;
    logic [DW-1:0] a;
    a = {1'b0, {(DW-1){1'b1}}};
    send_frame(2 * NB, a, 1, 3'b100, model_crc4(a, 1, 3'b100));
    n_checks++;
    if (exp_flags !== 4'b0101) begin
      n_fail++; $display("FAIL model_add_ovf flags got=%b required=0101", exp_flags);
    end
    expect_beat("add_ovf", 1);
    send_frame(2 * NB, 0, 1, 3'b101, model_crc4(0, 1, 3'b101));
    n_checks++;
    if (out_valid === 1'b1 && (out_result !== '1 || out_flags !== 4'b1001)) begin
      n_fail++; $display("FAIL sub_0_1 got=%h/%b required=all-ones/1001", out_result, out_flags);
    end
    expect_beat("sub_0_1", 0);
    a = '1;
    send_frame(2 * NB, a, 1, 3'b100, model_crc4(a, 1, 3'b100));
    n_checks++;
    if (exp_res !== '0 || exp_flags !== 4'b1010) begin
      n_fail++; $display("FAIL model_wrap got=%h/%b required=0/1010", exp_res, exp_flags);
    end
    expect_beat("add_wrap", 0);
  endtask

  task automatic test_data_error;
    send_frame(2 * NB - 1, 32'h11, 32'h22, 3'b100, 4'h0);
    expect_beat("short_frame", 0);
    send_frame(2 * NB + 1, 32'h11, 32'h22, 3'b100, 4'h0);
    expect_beat("long_frame", 0);
    send_frame(0, 0, 0, 3'b100, 4'h0);
    expect_beat("ctl_first", 0);
    send_frame(20, 5, 6, 3'b000, model_crc4(5, 6, 3'b000));
    expect_beat("very_long_frame", 0);
  endtask

  task automatic test_crc_op_error;
    logic [3:0] c;
    c = model_crc4(32'hDEAD_BEEF, 32'h1234_5678, 3'b001) ^ 4'b0100;
    send_frame(2 * NB, 32'hDEAD_BEEF, 32'h1234_5678, 3'b001, c);
    expect_beat("crc_flip", 0);
    for (int k = 0; k < 4; k++) begin
      logic [2:0] op;
      op = (k == 0) ? 3'b010 : (k == 1) ? 3'b011 : (k == 2) ? 3'b110 : 3'b111;
      send_frame(2 * NB, 32'h55, 32'hAA, op, model_crc4(32'h55, 32'hAA, op));
      expect_beat("bad_op", 0);
    end
    send_frame(2 * NB, 32'h55, 32'hAA, 3'b011, model_crc4(32'h55, 32'hAA, 3'b011) ^ 4'h1);
    expect_beat("crc_before_op", 0);
  endtask

  task automatic test_hold_and_reset;
    logic [DW+18:0] snap;
    int n;
    send_frame(2 * NB, 32'hF0F0_0F0F, 32'h0FF0_F00F, 3'b001,
               model_crc4(32'hF0F0_0F0F, 32'h0FF0_F00F, 3'b001));
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    snap = {out_valid, out_err, out_result, out_flags, out_crc, out_err_code};
    in_valid = 1'b1; in_ctl = 1'b1; in_data = 8'h40;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, out_err, out_result, out_flags, out_crc, out_err_code} !== snap ||
          in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable cycle=%0d got=%h in_ready=%0b required=%h in_ready=0", i,
                 {out_valid, out_err, out_result, out_flags, out_crc, out_err_code}, in_ready, snap);
      end
    end
    in_valid = 1'b0; in_ctl = 1'b0;
    expect_beat("hold_or", 0);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL hold_release out_valid=%0b in_ready=%0b required=0/1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    send_frame(2 * NB, 77, 33, 3'b101, model_crc4(77, 33, 3'b101));
    expect_beat("after_hold", 0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, out_err, out_result, out_flags, out_crc, out_err_code} !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe_reset got=%h in_ready=%0b required=0 in_ready=1",
               {out_valid, out_err, out_result, out_flags, out_crc, out_err_code}, in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(2 * NB, 1000, 24, 3'b100, model_crc4(1000, 24, 3'b100));
    expect_beat("after_reset", 0);
  endtask

  task automatic test_random;
    for (int f = 0; f < 1000; f++) begin
      logic [DW-1:0] a, b;
      logic [2:0] op;
      logic [3:0] c;
      int nd, kind;
      a = DW'({$urandom, $urandom});
      b = DW'({$urandom, $urandom});
      if ($urandom_range(0, 7) == 0) b = a;
      op = 3'($urandom);
      if ($urandom_range(0, 3) != 0) op = {op[2], 1'b0, op[0]};
      kind = $urandom_range(0, 9);
      nd = 2 * NB;
      c = model_crc4(a, b, op);
      if (kind == 0) begin
        nd = $urandom_range(0, 2 * NB + 4);
        if (nd == 2 * NB) nd = 2 * NB + 2;
      end else if (kind == 1) begin
        c = c ^ 4'($urandom_range(1, 15));
      end
      send_frame(nd, a, b, op, c);
      expect_beat("random", $urandom_range(0, 2));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset;
    test_add_basic;
    test_overflow;
    test_data_error;
    test_crc_op_error;
    test_hold_and_reset;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
